// File: rtl/brick_mem_arbiter_pkg.sv
// Brick memory arbiter shared types and widths.
// Address/health widths and the load slot payload.
package brick_mem_arbiter_pkg;

  localparam int BRICK_AW = 10;
  localparam int BRICK_HW = 2;
  localparam int BRICKNUM = 1 << BRICK_AW;

  localparam logic [BRICK_AW-1:0] A_ONE = 1;
  localparam logic [BRICK_HW-1:0] H_ONE = 1;

  typedef struct packed {
    logic [BRICK_AW-1:0] addr;
    logic [BRICK_HW-1:0] health;
  } load_t;

endpackage

// File: rtl/brick_mem_arbiter_req_slot.sv
// Requester slot: busy flag, held payload, overrun.
// A strobe in the ack cycle re-arms the slot.
module req_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_i,
  input  logic         ack_i,
  input  logic [W-1:0] data_i,
  output logic         busy_o,
  output logic         overrun_o,
  output logic [W-1:0] data_o
);

  logic         busy_q, busy_d;
  logic         ovr_q, ovr_d;
  logic [W-1:0] data_q, data_d;
  logic         accept;

  // Accept when free or finishing; a strobe mid-service is an overrun.
  always_comb begin
    accept = req_i && (!busy_q || ack_i);
    busy_d = busy_q;
    data_d = data_q;
    ovr_d  = ovr_q;
    if (accept) begin
      busy_d = 1'b1;
      data_d = data_i;
    end else if (ack_i) begin
      busy_d = 1'b0;
    end
    if (req_i && busy_q && !ack_i) ovr_d = 1'b1;
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      ovr_q  <= ovr_d;
      data_q <= data_d;
    end
  end

  assign busy_o    = busy_q;
  assign overrun_o = ovr_q;
  assign data_o    = data_q;

endmodule

// File: rtl/brick_mem_arbiter.sv
// Arbitrates loader, collision and renderer access
// to the brick health RAM; tracks hit points left.
module brick_mem_arbiter
  import brick_mem_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                load_req,
  input  logic [BRICK_AW-1:0] load_addr,
  input  logic [BRICK_HW-1:0] load_health,
  input  logic                load_done,
  input  logic [BRICK_AW-1:0] total_health,
  input  logic                hit_req,
  input  logic [BRICK_AW-1:0] hit_addr,
  input  logic                rd_req,
  input  logic [BRICK_AW-1:0] rd_addr,
  output logic                load_ack,
  output logic                hit_ack,
  output logic                rd_ack,
  output logic [BRICK_HW-1:0] hit_old,
  output logic [BRICK_HW-1:0] rd_health,
  output logic                load_busy,
  output logic                hit_busy,
  output logic                rd_busy,
  output logic                overrun,
  output logic [BRICK_AW-1:0] mem_addr,
  output logic [BRICK_HW-1:0] mem_wdata,
  output logic                mem_we,
  input  logic [BRICK_HW-1:0] mem_rdata,
  output logic [BRICK_AW-1:0] remaining,
  output logic                level_clear
);

  typedef enum logic [2:0] {
    IDLE, LOAD_WR, HIT_RD, HIT_WR, RD_RD, RD_DONE
  } state_t;

  state_t              state_q, state_d;
  load_t               ld_in, ld_q;
  logic [BRICK_AW-1:0] hit_q, rd_q;
  logic [2:0]          ovr;
  logic                dec;
  logic                done_q, armed_q, armed_d;
  logic [BRICK_AW-1:0] rem_q, rem_d;
  logic                clr_q, clr_d;
  logic                rise, fall;

  assign ld_in = '{addr: load_addr, health: load_health};

  req_slot #(.W($bits(load_t))) u_load (
    .clk       (clk),
    .rst_n     (resetn),
    .req_i     (load_req),
    .ack_i     (load_ack),
    .data_i    (ld_in),
    .busy_o    (load_busy),
    .overrun_o (ovr[0]),
    .data_o    (ld_q)
  );

  req_slot #(.W(BRICK_AW)) u_hit (
    .clk       (clk),
    .rst_n     (resetn),
    .req_i     (hit_req),
    .ack_i     (hit_ack),
    .data_i    (hit_addr),
    .busy_o    (hit_busy),
    .overrun_o (ovr[1]),
    .data_o    (hit_q)
  );

  req_slot #(.W(BRICK_AW)) u_rd (
    .clk       (clk),
    .rst_n     (resetn),
    .req_i     (rd_req),
    .ack_i     (rd_ack),
    .data_i    (rd_addr),
    .busy_o    (rd_busy),
    .overrun_o (ovr[2]),
    .data_o    (rd_q)
  );

  assign overrun = |ovr;

  // Next state and RAM/ack outputs; grant is load > hit > rd.
  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    load_ack  = 1'b0;
    hit_ack   = 1'b0;
    rd_ack    = 1'b0;
    hit_old   = '0;
    rd_health = '0;
    dec       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_busy)     state_d = LOAD_WR;
        else if (hit_busy) state_d = HIT_RD;
        else if (rd_busy)  state_d = RD_RD;
      end
      LOAD_WR: begin
        mem_addr  = ld_q.addr;
        mem_wdata = ld_q.health;
        mem_we    = 1'b1;
        load_ack  = 1'b1;
        state_d   = IDLE;
      end
      HIT_RD: begin
        mem_addr = hit_q;
        state_d  = HIT_WR;
      end
      HIT_WR: begin
        mem_addr = hit_q;
        hit_old  = mem_rdata;
        hit_ack  = 1'b1;
        if (mem_rdata != '0) begin
          mem_we    = 1'b1;
          mem_wdata = mem_rdata - H_ONE;
          dec       = 1'b1;
        end
        state_d = IDLE;
      end
      RD_RD: begin
        mem_addr = rd_q;
        state_d  = RD_DONE;
      end
      RD_DONE: begin
        rd_health = mem_rdata;
        rd_ack    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Level bookkeeping; a load_done rise beats a same-cycle hit.
  always_comb begin
    rise    = load_done && !done_q;
    fall    = !load_done && done_q;
    armed_d = armed_q;
    rem_d   = rem_q;
    if (rise)      armed_d = 1'b1;
    else if (fall) armed_d = 1'b0;
    if (rise)
      rem_d = total_health;
    else if (dec && rem_q != '0)
      rem_d = rem_q - A_ONE;
    clr_d = armed_d && (rem_d == '0);
  end

  // FSM and level state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
      rem_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= load_done;
      armed_q <= armed_d;
      rem_q   <= rem_d;
      clr_q   <= clr_d;
    end
  end

  assign remaining   = rem_q;
  assign level_clear = clr_q;

endmodule
